// File: rtl/req_ack_responder.sv
// Responder side of the single-cycle req/ack handshake: returns one ack per accepted
// req after a fixed delay, polices pulse width and spacing, and counts events.
module req_ack_responder #(
  parameter int unsigned ACK_DELAY = 4,
  parameter int unsigned MIN_GAP   = 8,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             err_clr,
  output logic             ack,
  output logic             busy,
  output logic             err_short,
  output logic             err_wide,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] ack_count
);

  localparam int unsigned            GAP_W   = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0]       GAP_MAX = GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_HOLDOFF} state_e;

  logic                 req_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic [ACK_DELAY-1:0] line;
  logic                 rise;
  logic                 gap_ok;
  logic                 accept;
  state_e               state;

  always_comb begin
    rise   = req & ~req_q;
    gap_ok = (gap_cnt == GAP_MAX);
    accept = rise & gap_ok;
  end

  // NOTE: every flop below uses <= so all stages sample the pre-edge values;
  // blocking assignments here would collapse the delay line into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      gap_cnt   <= GAP_MAX;
      err_short <= 1'b0;
      err_wide  <= 1'b0;
    end else begin
      req_q <= req;
      if (accept)       gap_cnt <= GAP_W'(1);
      else if (!gap_ok) gap_cnt <= gap_cnt + GAP_W'(1);
      // A new violation in the same cycle as err_clr keeps the flag set.
      err_wide  <= (req & req_q)   | (err_wide  & ~err_clr);
      err_short <= (rise & ~gap_ok) | (err_short & ~err_clr);
    end
  end

  // NOTE: the delay line is cleared on reset on purpose: in-flight acks are
  // dropped rather than delivered into a freshly reset link.
  always_ff @(posedge clk) begin
    if (rst) begin
      line      <= '0;
      req_count <= '0;
      ack_count <= '0;
    end else begin
      line[0] <= accept;
      for (int i = 1; i < int'(ACK_DELAY); i++) line[i] <= line[i-1];
      if (accept) req_count <= req_count + CNT_W'(1);
      if (ack)    ack_count <= ack_count + CNT_W'(1);
    end
  end

  assign ack = line[ACK_DELAY-1];

  // busy covers every stage except the output one, so a one-stage line is never busy.
  if (ACK_DELAY == 1) begin : g_no_busy
    assign busy = 1'b0;
  end else begin : g_busy
    assign busy = |line[ACK_DELAY-2:0];
  end

  // Protocol phase, derived from existing state for coverage only.
  always_comb begin
    state = ST_IDLE;
    if (busy)         state = ST_PENDING;
    else if (!gap_ok) state = ST_HOLDOFF;
  end

  c_pending_to_holdoff : cover property (@(posedge clk) disable iff (rst)
    ($past(state) == ST_PENDING) && (state == ST_HOLDOFF));
  c_pending_to_idle    : cover property (@(posedge clk) disable iff (rst)
    ($past(state) == ST_PENDING) && (state == ST_IDLE));
  c_holdoff_to_idle    : cover property (@(posedge clk) disable iff (rst)
    ($past(state) == ST_HOLDOFF) && (state == ST_IDLE));

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder: three parameterisations driven cycle by
// cycle, outputs compared against hand-derived per-cycle expectations.
module tb_req_ack_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  // Instance A: ACK_DELAY=4, MIN_GAP=8, CNT_W=32
  logic        rst_a = 1'b1, req_a = 1'b0, clr_a = 1'b0;
  logic        ack_a, busy_a, es_a, ew_a;
  logic [31:0] rc_a, ac_a;
  // Instance B: ACK_DELAY=1, MIN_GAP=2, CNT_W=32
  logic        rst_b = 1'b1, req_b = 1'b0, clr_b = 1'b0;
  logic        ack_b, busy_b, es_b, ew_b;
  logic [31:0] rc_b, ac_b;
  // Instance C: ACK_DELAY=4, MIN_GAP=2, CNT_W=2 (overlapping acks, counter wrap)
  logic        rst_c = 1'b1, req_c = 1'b0, clr_c = 1'b0;
  logic        ack_c, busy_c, es_c, ew_c;
  logic [1:0]  rc_c, ac_c;

  req_ack_responder #(.ACK_DELAY(4), .MIN_GAP(8), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .err_clr(clr_a), .ack(ack_a), .busy(busy_a),
    .err_short(es_a), .err_wide(ew_a), .req_count(rc_a), .ack_count(ac_a));

  req_ack_responder #(.ACK_DELAY(1), .MIN_GAP(2), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .err_clr(clr_b), .ack(ack_b), .busy(busy_b),
    .err_short(es_b), .err_wide(ew_b), .req_count(rc_b), .ack_count(ac_b));

  req_ack_responder #(.ACK_DELAY(4), .MIN_GAP(2), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .err_clr(clr_c), .ack(ack_c), .busy(busy_c),
    .err_short(es_c), .err_wide(ew_c), .req_count(rc_c), .ack_count(ac_c));

  // Inputs for posedge n are set just after posedge n-1; the negedge before posedge n
  // shows the outputs the spec calls "@n". Flag vectors are {ack, busy, err_short, err_wide}.

  task automatic test_reset();
    logic [3:0] f;
    for (int n = 0; n <= 3; n++) begin
      rst_a = 1'b1; req_a = (n == 1); clr_a = 1'b0;
      @(negedge clk);
      if (n >= 2) begin
        f = {ack_a, busy_a, es_a, ew_a};
        total_cnt++;
        if (f !== 4'b0000) $display("FAIL reset flags @%0d: got %b exp 0000", n, f);
        else pass_cnt++;
        total_cnt++;
        if (rc_a !== 32'd0 || ac_a !== 32'd0)
          $display("FAIL reset counts @%0d: got %0d/%0d exp 0/0", n, rc_a, ac_a);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    logic [3:0] f, e;
    for (int n = 0; n <= 20; n++) begin
      rst_a = (n <= 1); req_a = (n == 10); clr_a = 1'b0;
      @(negedge clk);
      if (n >= 2) begin
        f = {ack_a, busy_a, es_a, ew_a};
        e = {n == 14, n >= 11 && n <= 13, 1'b0, 1'b0};
        total_cnt++;
        if (f !== e) $display("FAIL single flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
        total_cnt++;
        if (rc_a !== 32'(n >= 11) || ac_a !== 32'(n >= 15))
          $display("FAIL single counts @%0d: got %0d/%0d exp %0d/%0d", n, rc_a, ac_a,
                   n >= 11, n >= 15);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] f, e;
    int er, ea;
    for (int n = 0; n <= 25; n++) begin
      rst_a = (n <= 1); req_a = (n == 10 || n == 18); clr_a = 1'b0;
      @(negedge clk);
      if (n >= 2) begin
        f  = {ack_a, busy_a, es_a, ew_a};
        e  = {n == 14 || n == 22, (n >= 11 && n <= 13) || (n >= 19 && n <= 21), 1'b0, 1'b0};
        er = (n >= 19) ? 2 : (n >= 11) ? 1 : 0;
        ea = (n >= 23) ? 2 : (n >= 15) ? 1 : 0;
        total_cnt++;
        if (f !== e) $display("FAIL b2b flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
        total_cnt++;
        if (rc_a !== 32'(er) || ac_a !== 32'(ea))
          $display("FAIL b2b counts @%0d: got %0d/%0d exp %0d/%0d", n, rc_a, ac_a, er, ea);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_short_gap();
    logic [3:0] f, e;
    for (int n = 0; n <= 24; n++) begin
      rst_a = (n <= 1); req_a = (n == 10 || n == 17); clr_a = (n == 20);
      @(negedge clk);
      if (n >= 2) begin
        f = {ack_a, busy_a, es_a, ew_a};
        e = {n == 14, n >= 11 && n <= 13, n >= 18 && n <= 20, 1'b0};
        total_cnt++;
        if (f !== e) $display("FAIL short flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
        total_cnt++;
        if (rc_a !== 32'(n >= 11) || ac_a !== 32'(n >= 15))
          $display("FAIL short counts @%0d: got %0d/%0d exp %0d/%0d", n, rc_a, ac_a,
                   n >= 11, n >= 15);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wide();
    logic [3:0] f, e;
    for (int n = 0; n <= 20; n++) begin
      rst_a = (n <= 1); req_a = (n == 10 || n == 11); clr_a = 1'b0;
      @(negedge clk);
      if (n >= 2) begin
        f = {ack_a, busy_a, es_a, ew_a};
        e = {n == 14, n >= 11 && n <= 13, 1'b0, n >= 12};
        total_cnt++;
        if (f !== e) $display("FAIL wide flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
        total_cnt++;
        if (rc_a !== 32'(n >= 11)) $display("FAIL wide req_count @%0d: got %0d exp %0d", n, rc_a, n >= 11);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_set_wins();
    logic [3:0] f, e;
    for (int n = 0; n <= 16; n++) begin
      rst_a = (n <= 1); req_a = (n == 10 || n == 11); clr_a = (n == 11 || n == 13);
      @(negedge clk);
      if (n >= 2) begin
        f = {ack_a, busy_a, es_a, ew_a};
        e = {n == 14, n >= 11 && n <= 13, 1'b0, n == 12 || n == 13};
        total_cnt++;
        if (f !== e) $display("FAIL setwins flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] f, e;
    int er, ea;
    for (int n = 0; n <= 20; n++) begin
      rst_a = (n <= 1 || n == 12); req_a = (n == 10 || n == 13); clr_a = 1'b0;
      @(negedge clk);
      if (n >= 2) begin
        f  = {ack_a, busy_a, es_a, ew_a};
        e  = {n == 17, n == 11 || n == 12 || (n >= 14 && n <= 16), 1'b0, 1'b0};
        er = (n == 11 || n == 12 || n >= 14) ? 1 : 0;
        ea = (n >= 18) ? 1 : 0;
        total_cnt++;
        if (f !== e) $display("FAIL midrst flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
        total_cnt++;
        if (rc_a !== 32'(er) || ac_a !== 32'(ea))
          $display("FAIL midrst counts @%0d: got %0d/%0d exp %0d/%0d", n, rc_a, ac_a, er, ea);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_min_delay();
    logic [3:0] f, e;
    int er, ea;
    for (int n = 0; n <= 19; n++) begin
      rst_b = (n <= 1); req_b = (n == 10 || n == 12 || n == 15 || n == 16); clr_b = (n == 15);
      @(negedge clk);
      if (n >= 2) begin
        f  = {ack_b, busy_b, es_b, ew_b};
        e  = {n == 11 || n == 13 || n == 16, 1'b0, 1'b0, n >= 17};
        er = (n >= 16) ? 3 : (n >= 13) ? 2 : (n >= 11) ? 1 : 0;
        ea = (n >= 17) ? 3 : (n >= 14) ? 2 : (n >= 12) ? 1 : 0;
        total_cnt++;
        if (f !== e) $display("FAIL mindly flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
        total_cnt++;
        if (rc_b !== 32'(er) || ac_b !== 32'(ea))
          $display("FAIL mindly counts @%0d: got %0d/%0d exp %0d/%0d", n, rc_b, ac_b, er, ea);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overlap_wrap();
    int reqs [5] = '{10, 12, 14, 16, 18};
    logic [3:0] f, e;
    logic is_ack;
    int er, ea;
    for (int n = 0; n <= 24; n++) begin
      rst_c = (n <= 1); clr_c = 1'b0;
      req_c = 1'b0;
      foreach (reqs[i]) if (reqs[i] == n) req_c = 1'b1;
      @(negedge clk);
      if (n >= 2) begin
        er = 0; ea = 0; is_ack = 1'b0;
        foreach (reqs[i]) begin
          if (reqs[i] < n)     er++;
          if (reqs[i] + 4 < n) ea++;
          if (reqs[i] + 4 == n) is_ack = 1'b1;
        end
        f = {ack_c, busy_c, es_c, ew_c};
        e = {is_ack, n >= 11 && n <= 21, 1'b0, 1'b0};
        total_cnt++;
        if (f !== e) $display("FAIL overlap flags @%0d: got %b exp %b", n, f, e);
        else pass_cnt++;
        total_cnt++;
        if (rc_c !== 2'(er % 4) || ac_c !== 2'(ea % 4))
          $display("FAIL overlap counts @%0d: got %0d/%0d exp %0d/%0d", n, rc_c, ac_c,
                   er % 4, ea % 4);
        else pass_cnt++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_short_gap();
    test_wide();
    test_set_wins();
    test_mid_reset();
    test_min_delay();
    test_overlap_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
